// File: rtl/i2c_ram_arbiter.sv
// Arbitrates a single-port RAM between synchronised I2C slave strobes (fixed priority) and a host req/ack port.
// Optional access/stall counters are built when I2C_ARB_STATS_EN is defined.
module i2c_ram_arbiter #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              i2c_wr_en,
    input  logic              i2c_rd_en,
    input  logic [ADDR_W-1:0] i2c_addr,
    input  logic [DATA_W-1:0] i2c_wdata,
    output logic [DATA_W-1:0] i2c_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [15:0]       stat_i2c_cnt,
    output logic [15:0]       stat_stall
);

    typedef enum logic [2:0] {
        IDLE, I2C_WR, I2C_RD, I2C_RWAIT, HOST_WR, HOST_RD, HOST_RWAIT
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] wr_sync, rd_sync;
    logic                   wr_sync_d, rd_sync_d;
    logic                   wr_rise, rd_rise;
    logic                   wr_pend, rd_pend;
    logic [ADDR_W-1:0]      wr_addr, rd_addr;
    logic [DATA_W-1:0]      wr_data;

    // Strobe synchronisers with a registered rising-edge detect
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_sync   <= '0;
            rd_sync   <= '0;
            wr_sync_d <= 1'b0;
            rd_sync_d <= 1'b0;
            wr_rise   <= 1'b0;
            rd_rise   <= 1'b0;
        end else begin
            wr_sync   <= {wr_sync[SYNC_STAGES-2:0], i2c_wr_en};
            rd_sync   <= {rd_sync[SYNC_STAGES-2:0], i2c_rd_en};
            wr_sync_d <= wr_sync[SYNC_STAGES-1];
            rd_sync_d <= rd_sync[SYNC_STAGES-1];
            wr_rise   <= wr_sync[SYNC_STAGES-1] & ~wr_sync_d;
            rd_rise   <= rd_sync[SYNC_STAGES-1] & ~rd_sync_d;
        end
    end

    // Pending flags: a fresh edge wins over the clear issued when the FSM takes the request
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_pend <= 1'b0;
            rd_pend <= 1'b0;
            wr_addr <= '0;
            rd_addr <= '0;
            wr_data <= '0;
        end else begin
            if (wr_rise) begin
                wr_pend <= 1'b1;
                wr_addr <= i2c_addr;
                wr_data <= i2c_wdata;
            end else if (state == IDLE && wr_pend) begin
                wr_pend <= 1'b0;
            end
            if (rd_rise) begin
                rd_pend <= 1'b1;
                rd_addr <= i2c_addr;
            end else if (state == IDLE && !wr_pend && rd_pend) begin
                rd_pend <= 1'b0;
            end
        end
    end

    // Arbitration FSM; host_req is ignored during the ack cycle so a held request is not re-run
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            i2c_rdata  <= '0;
            host_ack   <= 1'b0;
            host_rdata <= '0;
        end else begin
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;
            host_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_pend) begin
                        ram_en    <= 1'b1;
                        ram_we    <= 1'b1;
                        ram_addr  <= wr_addr;
                        ram_wdata <= wr_data;
                        state     <= I2C_WR;
                    end else if (rd_pend) begin
                        ram_en   <= 1'b1;
                        ram_addr <= rd_addr;
                        state    <= I2C_RD;
                    end else if (host_req && !host_ack) begin
                        ram_en   <= 1'b1;
                        ram_we   <= host_we;
                        ram_addr <= host_addr;
                        if (host_we) begin
                            ram_wdata <= host_wdata;
                            state     <= HOST_WR;
                        end else begin
                            state     <= HOST_RD;
                        end
                    end
                end
                I2C_WR:     state <= IDLE;
                I2C_RD:     state <= I2C_RWAIT;
                I2C_RWAIT: begin
                    i2c_rdata <= ram_rdata;
                    state     <= IDLE;
                end
                HOST_WR: begin
                    host_ack <= 1'b1;
                    state    <= IDLE;
                end
                HOST_RD:    state <= HOST_RWAIT;
                HOST_RWAIT: begin
                    host_rdata <= ram_rdata;
                    host_ack   <= 1'b1;
                    state      <= IDLE;
                end
                default:    state <= IDLE;
            endcase
        end
    end

`ifdef I2C_ARB_STATS_EN
    logic [15:0] i2c_cnt_q, stall_q;

    // Saturating service and stall counters
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            i2c_cnt_q <= '0;
            stall_q   <= '0;
        end else begin
            if (state == IDLE && (wr_pend || rd_pend) && i2c_cnt_q != 16'hFFFF)
                i2c_cnt_q <= i2c_cnt_q + 16'd1;
            if (host_req && !host_ack && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'd1;
        end
    end

    assign stat_i2c_cnt = i2c_cnt_q;
    assign stat_stall   = stall_q;
`else
    assign stat_i2c_cnt = 16'h0000;
    assign stat_stall   = 16'h0000;
`endif

endmodule
